// File: rtl/bcd_count_ctrl.sv
// Four-digit BCD run/pause counter with multiplexed active-low seven-segment scan.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_count_ctrl #(
    parameter int PRESCALE = 100000,
    parameter int SCAN_DIV = 1000
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        running,
    output logic        ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic [SW-1:0]  scan;
    logic [1:0]     sel;
    logic           ss_q;
    logic           ss_edge;
    logic           tick;
    logic [3:0]     cur;

    // Ripple a +1 through the four BCD digits within a single cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        logic        carry;
        r     = d;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = '0;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        ss_edge = start_stop & ~ss_q;
        tick    = (state == RUN) && (presc == PW'(PRESCALE - 1));
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state   <= IDLE;
            digits  <= '0;
            presc   <= '0;
            scan    <= '0;
            sel     <= '0;
            ss_q    <= 1'b0;
            ovf     <= 1'b0;
            running <= 1'b0;
        end else begin
            ss_q <= start_stop;
            ovf  <= 1'b0;

            if (scan == SW'(SCAN_DIV - 1)) begin
                scan <= '0;
                sel  <= sel + 2'd1;
            end else begin
                scan <= scan + 1'b1;
            end

            // clear wins over tick and swallows any coincident start_stop edge
            if (clear) begin
                state   <= IDLE;
                digits  <= '0;
                presc   <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (ss_edge) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc  <= '0;
                            digits <= bcd_inc(digits);
                            ovf    <= (digits == 16'h9999);
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (ss_edge) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (ss_edge) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        an      = 4'b1111;
        an[sel] = 1'b0;

        case (sel)
            2'd0:    cur = digits[3:0];
            2'd1:    cur = digits[7:4];
            2'd2:    cur = digits[11:8];
            default: cur = digits[15:12];
        endcase

        case (cur)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        case (sel)
            2'd1:    if (digits[15:4]  == '0) seg = '1;
            2'd2:    if (digits[15:8]  == '0) seg = '1;
            2'd3:    if (digits[15:12] == '0) seg = '1;
            default: ;
        endcase
`endif
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: directed vector table, scan/overflow sequences and random
// stimulus, all checked against an integer-arithmetic model of the counter.
module tb_bcd_count_ctrl;

    localparam int P = 4;
    localparam int S = 2;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        running;
    logic        ovf;

    bcd_count_ctrl #(.PRESCALE(P), .SCAN_DIV(S)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits),
        .an         (an),
        .seg        (seg),
        .running    (running),
        .ovf        (ovf)
    );

    always #5 mclk = ~mclk;

    int tests = 0;
    int fails = 0;

    // Model: 0 = idle, 1 = run, 2 = pause; count kept as a plain integer.
    int m_mode = 0;
    int m_count = 0;
    int m_pre = 0;
    int m_scan = 0;
    int m_sel = 0;
    bit m_ssq = 0;
    bit m_ovf = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] model_seg();
        int above = m_count / pow10(m_sel);
`ifdef LEADING_ZERO_BLANK_EN
        if (m_sel > 0 && above == 0) return 7'b1111111;
`endif
        return seg_of(above % 10);
    endfunction

    task automatic model_step(input bit ss, input bit clr, input bit rst);
        bit edge_seen;
        if (rst) begin
            m_mode = 0; m_count = 0; m_pre = 0; m_scan = 0; m_sel = 0;
            m_ssq = 0; m_ovf = 0;
            return;
        end
        edge_seen = ss && !m_ssq;
        m_ssq = ss;
        m_ovf = 0;
        m_scan++;
        if (m_scan == S) begin
            m_scan = 0;
            m_sel = (m_sel + 1) % 4;
        end
        if (clr) begin
            m_mode = 0; m_count = 0; m_pre = 0;
        end else if (m_mode == 1) begin
            if (m_pre == P - 1) begin
                m_pre = 0;
                if (m_count == 9999) m_ovf = 1;
                m_count = (m_count + 1) % 10000;
            end else begin
                m_pre++;
            end
            if (edge_seen) m_mode = 2;
        end else if (m_mode == 2) begin
            if (edge_seen) m_mode = 1;
        end else begin
            m_pre = 0;
            if (edge_seen) m_mode = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 after.
    task automatic cyc(input bit ss, input bit clr, input bit rst);
        logic [3:0] exp_an;
        @(negedge mclk);
        start_stop = ss;
        clear      = clr;
        reset      = rst;
        @(posedge mclk);
        model_step(ss, clr, rst);
        #1;
        exp_an = 4'b1111;
        exp_an[m_sel] = 1'b0;
        check("model", {2'b00, digits, an, seg, running, ovf},
              {2'b00, to_bcd(m_count), exp_an, model_seg(), (m_mode == 1), m_ovf});
    endtask

    typedef struct {
        bit          rst;
        bit          ss;
        bit          clr;
        int          n;
        logic [15:0] dig;
        logic        run;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [6:0] exp_seg[4];
        int guard;

        tbl[0]  = '{1'b1, 1'b0, 1'b0,  2, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0,  1, 16'h0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 40, 16'h0010, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0,  1, 16'h0010, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 20, 16'h0010, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  1, 16'h0010, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0,  2, 16'h0010, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0,  1, 16'h0011, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 50, 16'h0011, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0,  1, 16'h0011, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0,  1, 16'h0011, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0,  3, 16'h0012, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1,  1, 16'h0000, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0,  5, 16'h0000, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0,  1, 16'h0000, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0,  8, 16'h0002, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0,  1, 16'h0000, 1'b0};

        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].ss, tbl[i].clr, tbl[i].rst);
            check($sformatf("vec%0d_digits", i), {16'h0, digits}, {16'h0, tbl[i].dig});
            check($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, tbl[i].run});
            check($sformatf("vec%0d_ovf", i), {31'h0, ovf}, 32'h0);
        end
        check("reset_an", {28'h0, an}, {28'h0, 4'b1110});
        check("reset_seg", {25'h0, seg}, {25'h0, 7'b1000000});

        // Count to 0305, pause, then watch one full scan rotation.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        guard = 0;
        while (m_count != 305 && guard < 5000) begin
            cyc(0, 0, 0);
            guard++;
        end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("scan_digits", {16'h0, digits}, {16'h0, 16'h0305});
        guard = 0;
        while (an !== 4'b0111 && guard < 20) begin cyc(0, 0, 0); guard++; end
        while (an !== 4'b1110 && guard < 20) begin cyc(0, 0, 0); guard++; end
        check("scan_sync", {31'h0, (guard < 20)}, 32'h1);
        exp_seg[0] = 7'b0010010;
        exp_seg[1] = 7'b1000000;
        exp_seg[2] = 7'b0110000;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg[3] = 7'b1111111;
`else
        exp_seg[3] = 7'b1000000;
`endif
        for (int k = 0; k < 4; k++) begin
            check($sformatf("scan_an%0d", k), {28'h0, an}, {28'h0, ~(4'b0001 << k)});
            check($sformatf("scan_seg%0d", k), {25'h0, seg}, {25'h0, exp_seg[k]});
            cyc(0, 0, 0);
            check($sformatf("scan_hold_an%0d", k), {28'h0, an}, {28'h0, ~(4'b0001 << k)});
            cyc(0, 0, 0);
        end

        // Random traffic: mostly steady levels, occasional toggles, rare clear/reset.
        for (int i = 0; i < 3000; i++) begin
            bit ss = ($urandom_range(0, 7) == 0) ? ~start_stop : start_stop;
            bit clr = ($urandom_range(0, 99) == 0);
            bit rst = ($urandom_range(0, 299) == 0);
            cyc(ss, clr, rst);
        end

        // Overflow: count from reset up to 9999, then one further tick.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        guard = 0;
        while (m_count != 9999 && guard < 45000) begin
            cyc(0, 0, 0);
            guard++;
        end
        check("reach_9999", {16'h0, digits}, {16'h0, 16'h9999});
        guard = 0;
        while (ovf !== 1'b1 && guard < 10) begin cyc(0, 0, 0); guard++; end
        check("ovf_seen", {31'h0, ovf}, 32'h1);
        check("ovf_digits", {16'h0, digits}, 32'h0);
        cyc(0, 0, 0);
        check("ovf_one_cycle", {31'h0, ovf}, 32'h0);

        // Reset mid-run: everything back to power-on values next cycle.
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("midrun_reset", {2'b00, digits, an, seg, running, ovf},
              {2'b00, 16'h0000, 4'b1110, 7'b1000000, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
